// File: rtl/act_lut_interp_pipe_pkg.sv
// Shared sizing helpers and pipeline constants for the activation LUT interpolator.
package act_lut_pkg;

    localparam int PIPE_LAT = 3;

    function automatic int ADDR_W(input int data_w, input int frac_w);
        return data_w - frac_w;
    endfunction

    function automatic int DEPTH(input int data_w, input int frac_w);
        return 32'sd1 << (data_w - frac_w);
    endfunction

endpackage

// File: rtl/act_lut_interp_pipe_lane.sv
// One lane of stage-2/3 interpolation arithmetic: a = base + ((next-base)*rem >>> FRAC_W).
// Build option ACT_INTERP_ROUND_EN switches the floor shift to round-half-up.
module act_interp_lane
    import act_lut_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] base,
    input  logic signed [DATA_W-1:0] next,
    input  logic        [FRAC_W-1:0] rem,
    output logic signed [DATA_W-1:0] a
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + FRAC_W + 2;

    logic signed [DIFF_W-1:0] diff_s;
    logic signed [PROD_W-1:0] diff_ext_s;
    logic signed [PROD_W-1:0] rem_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] prod_adj_s;
    logic signed [PROD_W-1:0] prod_r;
    logic signed [DATA_W-1:0] base2_r;
    logic signed [DATA_W-1:0] a_next_s;
    logic signed [DATA_W-1:0] a_r;

`ifdef ACT_INTERP_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND_HALF = {{(PROD_W-1){1'b0}}, 1'b1} << (FRAC_W-1);
`endif

    // Widen both operands to the product width so the signed multiply is exact.
    always_comb begin
        diff_s     = {next[DATA_W-1], next} - {base[DATA_W-1], base};
        diff_ext_s = {{(FRAC_W+1){diff_s[DIFF_W-1]}}, diff_s};
        rem_ext_s  = {{(DATA_W+2){1'b0}}, rem};
        prod_s     = diff_ext_s * rem_ext_s;
`ifdef ACT_INTERP_ROUND_EN
        prod_adj_s = prod_s + RND_HALF;
`else
        prod_adj_s = prod_s;
`endif
        // Result lies between base and next, so plain truncation cannot overflow.
        a_next_s   = base2_r + DATA_W'(prod_r >>> FRAC_W);
    end

    // Stage-2 product/base and stage-3 result registers, frozen together on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r  <= '0;
            base2_r <= '0;
            a_r     <= '0;
        end else if (en) begin
            prod_r  <= prod_adj_s;
            base2_r <= base;
            a_r     <= a_next_s;
        end
    end

    assign a = a_r;

endmodule

// File: rtl/act_lut_interp_pipe.sv
// 3-stage LUT + linear interpolation activation unit with shared run-time loadable table.
// Build option ACT_INTERP_ROUND_EN selects round-half-up interpolation in every lane.
module act_lut_interp_pipe
    import act_lut_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int LANES  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_W-1:0]     in_z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_W-1:0]     out_a,
    input  logic                        lut_we,
    input  logic [DATA_W-FRAC_W-1:0]    lut_waddr,
    input  logic [DATA_W-1:0]           lut_wdata
);

    localparam int LUT_AW    = ADDR_W(DATA_W, FRAC_W);
    localparam int LUT_DEPTH = DEPTH(DATA_W, FRAC_W);
    // Top segment of the positive range: no breakpoint above it, so hold flat.
    localparam logic [LUT_AW-1:0] MAX_POS_IDX = {1'b0, {(LUT_AW-1){1'b1}}};

    logic signed [DATA_W-1:0] lut_r [LUT_DEPTH];
    logic                     adv_s;
    logic                     v1_r;
    logic                     v2_r;
    logic                     v3_r;

    assign adv_s     = rst | ~v3_r | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = v3_r;

    // Valid chain: one global stall, bubbles travel like beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else if (adv_s) begin
            v1_r <= in_valid;
            v2_r <= v1_r;
            v3_r <= v2_r;
        end
    end

    // Breakpoint table; readers see the pre-edge contents during a write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_r[i] <= '0;
            end
        end else if (lut_we) begin
            lut_r[lut_waddr] <= lut_wdata;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic        [LUT_AW-1:0] addr_s;
        logic        [LUT_AW-1:0] naddr_s;
        logic        [FRAC_W-1:0] rem_s;
        logic signed [DATA_W-1:0] base_s;
        logic signed [DATA_W-1:0] next_s;
        logic signed [DATA_W-1:0] base1_r;
        logic signed [DATA_W-1:0] next1_r;
        logic        [FRAC_W-1:0] rem1_r;

        assign addr_s  = in_z[k*DATA_W+FRAC_W +: LUT_AW];
        assign rem_s   = in_z[k*DATA_W +: FRAC_W];
        // Index DEPTH-1 wraps to 0, which keeps the -1 -> 0 segment continuous.
        assign naddr_s = addr_s + {{(LUT_AW-1){1'b0}}, 1'b1};
        assign base_s  = lut_r[addr_s];
        assign next_s  = (addr_s == MAX_POS_IDX) ? base_s : lut_r[naddr_s];

        // Stage 1: table read results captured at acceptance.
        always_ff @(posedge clk) begin
            if (rst) begin
                base1_r <= '0;
                next1_r <= '0;
                rem1_r  <= '0;
            end else if (adv_s) begin
                base1_r <= base_s;
                next1_r <= next_s;
                rem1_r  <= rem_s;
            end
        end

        act_interp_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (adv_s),
            .base (base1_r),
            .next (next1_r),
            .rem  (rem1_r),
            .a    (out_a[k*DATA_W +: DATA_W])
        );
    end

endmodule
